// File: rtl/phase_sincos_pkg.sv
// Shared definitions for the phase_sincos phase-to-amplitude converter.
//   Q0..Q3         : quadrant codes taken from the top two reduced-phase bits
//   quarter_entry  : one quarter-wave table value, computed at elaboration
//   pack_cs        : packs {cos, sin} with cos in the upper half
// Optional build macro used elsewhere: PHASE_SINCOS_ROUND_EN.
package phase_sincos_pkg;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam real PI = 3.14159265358979323846;

  // round((2^(out_w-1)-1) * sin(pi/2 * j / 2^addr_w)); the argument is never
  // negative, so adding one half before truncation rounds to nearest.
  function automatic logic [31:0] quarter_entry(input int out_w, input int addr_w, input int j);
    real amp;
    real ang;
    amp = (2.0 ** (out_w - 1)) - 1.0;
    ang = (PI / 2.0) * real'(j) / (2.0 ** addr_w);
    return 32'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

  // c and s arrive zero-extended to 32 bits; result holds {c, s} in 2*w bits.
  function automatic logic [63:0] pack_cs(input logic [31:0] c, input logic [31:0] s, input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return ({32'd0, c} << w) | ({32'd0, s} & mask);
  endfunction

endpackage

// File: rtl/phase_sincos_if.sv
// AXI-Stream bundle for phase_sincos: input phase stream (i_*) and output
// {cos, sin} stream (o_*).
//   master : the environment side (drives i_tdata/i_tlast/i_tvalid, o_tready)
//   slave  : the converter side  (drives i_tready, o_tdata/o_tlast/o_tvalid)
interface phase_sincos_if #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 16
);
  logic [WIDTH-1:0]       i_tdata;
  logic                   i_tlast;
  logic                   i_tvalid;
  logic                   i_tready;
  logic [2*OUT_WIDTH-1:0] o_tdata;
  logic                   o_tlast;
  logic                   o_tvalid;
  logic                   o_tready;

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface

// File: rtl/sincos_quarter_rom.sv
// Quarter-wave sine table with two registered read ports (pipeline stage S2).
//   clk, reset, clear : clock, synchronous reset and flush (outputs to 0)
//   en_i              : shared read enable (pipeline advance)
//   addr_a_i/addr_b_i : read addresses, 0..2^ADDR_WIDTH
//   data_a_o/data_b_o : registered table values
module sincos_quarter_rom
  import phase_sincos_pkg::*;
#(
  parameter int OUT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH:0]   addr_a_i,
  input  logic [ADDR_WIDTH:0]   addr_b_i,
  output logic [OUT_WIDTH-1:0]  data_a_o,
  output logic [OUT_WIDTH-1:0]  data_b_o
);
  localparam int DEPTH = (1 << ADDR_WIDTH) + 1;

  logic [OUT_WIDTH-1:0] rom_s [DEPTH];
  logic [OUT_WIDTH-1:0] data_a_q;
  logic [OUT_WIDTH-1:0] data_b_q;

  for (genvar j = 0; j < DEPTH; j++) begin : g_entry
    assign rom_s[j] = OUT_WIDTH'(quarter_entry(OUT_WIDTH, ADDR_WIDTH, j));
  end

  // Registered dual-port read; holds while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      data_a_q <= {OUT_WIDTH{1'b0}};
      data_b_q <= {OUT_WIDTH{1'b0}};
    end else if (en_i) begin
      data_a_q <= rom_s[addr_a_i];
      data_b_q <= rom_s[addr_b_i];
    end else begin
      data_a_q <= data_a_q;
      data_b_q <= data_b_q;
    end
  end

  assign data_a_o = data_a_q;
  assign data_b_o = data_b_q;
endmodule

// File: rtl/phase_sincos.sv
// Phase-to-amplitude converter: signed phase in (2^(WIDTH-2) = pi), packed
// {cos, sin} out. Three-stage stallable pipeline: S1 decode, S2 table read,
// S3 sign apply. tlast travels alongside the data unchanged.
//   clk, reset, clear : clock, synchronous active-high reset, synchronous flush
//   bus (slave)       : i_* phase stream in, o_* {cos, sin} stream out
// Build macro PHASE_SINCOS_ROUND_EN: round the table index to nearest
// instead of truncating.
module phase_sincos
  import phase_sincos_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int OUT_WIDTH      = 16,
  parameter int LUT_ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  phase_sincos_if.slave bus
);
  localparam int A = LUT_ADDR_WIDTH;
  localparam logic [A:0] QUARTER = {1'b1, {A{1'b0}}};

  logic                   flush_s;
  logic                   advance_s;
  logic [WIDTH-2:0]       p_s;
  logic [1:0]             q_s;
  logic [A:0]             k_s;
  logic [A:0]             m_s;
  logic                   unused_bits_s;

  logic                   v1_q, last1_q;
  logic [1:0]             q1_q;
  logic [A:0]             k1_q, m1_q;
  logic                   v2_q, last2_q;
  logic [1:0]             q2_q;
  logic [OUT_WIDTH-1:0]   tk_s, tm_s;
  logic [OUT_WIDTH-1:0]   cos_d, sin_d;
  logic                   o_tvalid_q, o_tlast_q;
  logic [2*OUT_WIDTH-1:0] o_tdata_q;

  assign flush_s   = reset | clear;
  // Any free output slot lets the whole pipeline move; nothing is collapsed.
  assign advance_s = ~o_tvalid_q | bus.o_tready;
  // Ready stays high while flushing; any beat offered then is dropped.
  assign bus.i_tready = advance_s | flush_s;

`ifdef PHASE_SINCOS_ROUND_EN
  localparam logic [WIDTH-2:0] RND_INC = (WIDTH-1)'(1'b1) << (WIDTH - 4 - A);
  // Half an index step added modulo 2pi; a carry into the quadrant wraps.
  assign p_s = bus.i_tdata[WIDTH-2:0] + RND_INC;
`else
  assign p_s = bus.i_tdata[WIDTH-2:0];
`endif

  assign q_s = p_s[WIDTH-2:WIDTH-3];
  assign k_s = {1'b0, p_s[WIDTH-4:WIDTH-3-A]};
  assign m_s = QUARTER - k_s;
  assign unused_bits_s = &{1'b0, bus.i_tdata[WIDTH-1], p_s[WIDTH-4-A:0]};

  // S1: register quadrant, direct and mirror indices, tlast.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      q1_q    <= Q0;
      k1_q    <= {(A+1){1'b0}};
      m1_q    <= {(A+1){1'b0}};
    end else if (advance_s) begin
      v1_q    <= bus.i_tvalid;
      last1_q <= bus.i_tlast;
      q1_q    <= q_s;
      k1_q    <= k_s;
      m1_q    <= m_s;
    end else begin
      v1_q    <= v1_q;
      last1_q <= last1_q;
      q1_q    <= q1_q;
      k1_q    <= k1_q;
      m1_q    <= m1_q;
    end
  end

  sincos_quarter_rom #(
    .OUT_WIDTH  (OUT_WIDTH),
    .ADDR_WIDTH (A)
  ) u_rom (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .en_i     (advance_s),
    .addr_a_i (k1_q),
    .addr_b_i (m1_q),
    .data_a_o (tk_s),
    .data_b_o (tm_s)
  );

  // S2 side-band: valid, quadrant and tlast follow the table read.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
      q2_q    <= Q0;
    end else if (advance_s) begin
      v2_q    <= v1_q;
      last2_q <= last1_q;
      q2_q    <= q1_q;
    end else begin
      v2_q    <= v2_q;
      last2_q <= last2_q;
      q2_q    <= q2_q;
    end
  end

  // Quadrant selects which table value feeds each output and its sign.
  always_comb begin
    cos_d = tm_s;
    sin_d = tk_s;
    case (q2_q)
      Q0: begin cos_d = tm_s;  sin_d = tk_s;  end
      Q1: begin cos_d = -tk_s; sin_d = tm_s;  end
      Q2: begin cos_d = -tm_s; sin_d = -tk_s; end
      Q3: begin cos_d = tk_s;  sin_d = -tm_s; end
      default: begin cos_d = tm_s; sin_d = tk_s; end
    endcase
  end

  // S3: registered output beat.
  always_ff @(posedge clk) begin
    if (flush_s) begin
      o_tvalid_q <= 1'b0;
      o_tlast_q  <= 1'b0;
      o_tdata_q  <= {(2*OUT_WIDTH){1'b0}};
    end else if (advance_s) begin
      o_tvalid_q <= v2_q;
      o_tlast_q  <= last2_q;
      o_tdata_q  <= (2*OUT_WIDTH)'(pack_cs(32'(cos_d), 32'(sin_d), OUT_WIDTH));
    end else begin
      o_tvalid_q <= o_tvalid_q;
      o_tlast_q  <= o_tlast_q;
      o_tdata_q  <= o_tdata_q;
    end
  end

  assign bus.o_tvalid = o_tvalid_q;
  assign bus.o_tlast  = o_tlast_q;
  assign bus.o_tdata  = o_tdata_q;
endmodule

// File: tb/tb_phase_sincos.sv
module tb_phase_sincos;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] ph_a[$];
  bit          last_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] out_d[$];
  bit          out_l[$];
  int          stall_cycles;
  int          stall_changes;
  int          run_cycles;

  phase_sincos_if #(.WIDTH(16), .OUT_WIDTH(16)) bus ();

  phase_sincos #(.WIDTH(16), .OUT_WIDTH(16), .LUT_ADDR_WIDTH(10)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int round_away(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(-x + 0.5);
  endfunction

  // Reference: full-circle angle from the phase, cos/sin scaled and rounded.
  function automatic logic [31:0] model_cs(input logic [15:0] ph);
    int  p;
    int  n;
    real th;
    p = int'(ph[14:0]);
`ifdef PHASE_SINCOS_ROUND_EN
    p = (p + 4) % 32768;
`endif
    n = p / 8;
    th = 2.0 * PI * real'(n) / 4096.0;
    return {16'(round_away(32767.0 * $cos(th))), 16'(round_away(32767.0 * $sin(th)))};
  endfunction

  // Drives ph_a/last_a, collects accepted outputs into out_d/out_l.
  task automatic run_stream(input int n, input bit rand_rdy);
    int sent;
    int cyc;
    bit stalled;
    logic [31:0] held_d;
    logic held_l;
    sent = 0; cyc = 0; stalled = 1'b0; held_d = 32'd0; held_l = 1'b0;
    out_d.delete(); out_l.delete();
    stall_cycles = 0; stall_changes = 0;
    while ((out_d.size() < n) && (cyc < 4000)) begin
      @(posedge clk); #1;
      bus.o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < n) begin
        bus.i_tvalid = 1'b1; bus.i_tdata = ph_a[sent]; bus.i_tlast = last_a[sent];
      end else begin
        bus.i_tvalid = 1'b0; bus.i_tlast = 1'b0;
      end
      @(negedge clk);
      if (stalled) begin
        stall_cycles++;
        if (bus.o_tdata !== held_d || bus.o_tlast !== held_l || bus.o_tvalid !== 1'b1)
          stall_changes++;
      end
      if (bus.i_tvalid && bus.i_tready) sent++;
      if (bus.o_tvalid && bus.o_tready) begin
        out_d.push_back(bus.o_tdata);
        out_l.push_back(bus.o_tlast);
      end
      stalled = bus.o_tvalid && !bus.o_tready;
      held_d = bus.o_tdata; held_l = bus.o_tlast;
      cyc++;
    end
    run_cycles = cyc;
    @(posedge clk); #1;
    bus.i_tvalid = 1'b0; bus.i_tlast = 1'b0; bus.o_tready = 1'b1;
  endtask

  // Loads three beats with o_tready low so the pipeline stalls full.
  task automatic fill_stalled(input bit first_last);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.o_tready = 1'b0; bus.i_tvalid = 1'b1;
      bus.i_tdata = 16'(16'd1000 + 16'(i * 2000));
      bus.i_tlast = (i == 0) ? first_last : 1'b0;
    end
    @(posedge clk); #1;
    bus.i_tvalid = 1'b0; bus.i_tlast = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_tvalid !== 1'b0 || bus.o_tlast !== 1'b0 || bus.o_tdata !== 32'd0) begin
      errors++; $display("FAIL reset_out: valid=%b last=%b data=%h, want 0/0/0", bus.o_tvalid, bus.o_tlast, bus.o_tdata);
    end
    checks++;
    if (bus.i_tready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: i_tready=%b, want 1", bus.i_tready);
    end
  endtask

  task automatic test_directed;
    ph_a.delete(); last_a.delete(); exp_d.delete();
    ph_a = '{16'd0, 16'd8192, 16'd16384, 16'hE000, 16'hC000, 16'd4096, 16'h8000};
    exp_d = '{32'h7FFF0000, 32'h00007FFF, 32'h80010000, 32'h00008001, 32'h80010000, 32'h5A825A82, 32'h7FFF0000};
`ifdef PHASE_SINCOS_ROUND_EN
    ph_a.push_back(16'd4);      exp_d.push_back(32'h7FFF0032);
    ph_a.push_back(16'h7FFF);   exp_d.push_back(32'h7FFF0000);
`else
    ph_a.push_back(16'd7);      exp_d.push_back(32'h7FFF0000);
    ph_a.push_back(16'h7FFF);   exp_d.push_back(32'h7FFFFFCE);
`endif
    foreach (ph_a[i]) last_a.push_back(1'b0);
    run_stream(ph_a.size(), 1'b0);
    checks++;
    if (out_d.size() != ph_a.size()) begin
      errors++; $display("FAIL directed_count: got %0d, want %0d", out_d.size(), ph_a.size());
    end
    for (int i = 0; i < out_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (out_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL directed_%0d: phase %h got %h, want %h", i, ph_a[i], out_d[i], exp_d[i]);
      end
    end
    checks++;
    if (run_cycles != ph_a.size() + 3) begin
      errors++; $display("FAIL directed_latency: %0d cycles, want %0d", run_cycles, ph_a.size() + 3);
    end
  endtask

  task automatic test_random;
    ph_a.delete(); last_a.delete(); exp_d.delete();
    for (int i = 0; i < 150; i++) begin
      ph_a.push_back(16'($urandom));
      last_a.push_back(1'b0);
      exp_d.push_back(model_cs(ph_a[i]));
    end
    run_stream(150, 1'b0);
    checks++;
    if (out_d.size() != 150 || run_cycles != 153) begin
      errors++; $display("FAIL random_throughput: got %0d beats in %0d cycles, want 150 in 153", out_d.size(), run_cycles);
    end
    for (int i = 0; i < out_d.size(); i++) begin
      checks++;
      if (out_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL random_%0d: phase %h got %h, want %h", i, ph_a[i], out_d[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] base;
    base = 16'($urandom);
    ph_a.delete(); last_a.delete(); exp_d.delete();
    for (int i = 0; i < 100; i++) begin
      ph_a.push_back(16'(base + 16'(i)));
      last_a.push_back(1'b0);
      exp_d.push_back(model_cs(ph_a[i]));
    end
    run_stream(100, 1'b1);
    checks++;
    if (out_d.size() != 100) begin
      errors++; $display("FAIL bp_count: got %0d, want 100", out_d.size());
    end
    for (int i = 0; i < out_d.size(); i++) begin
      checks++;
      if (out_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL bp_%0d: phase %h got %h, want %h", i, ph_a[i], out_d[i], exp_d[i]);
      end
    end
    checks++;
    if (stall_changes != 0 || stall_cycles == 0) begin
      errors++; $display("FAIL bp_stable: %0d changes over %0d stalled cycles, want 0 over >0", stall_changes, stall_cycles);
    end
  endtask

  task automatic test_tlast;
    ph_a.delete(); last_a.delete(); exp_d.delete();
    for (int i = 0; i < 8; i++) begin
      ph_a.push_back((i == 4) ? 16'd0 : 16'($urandom));
      last_a.push_back(i == 4);
      exp_d.push_back((i == 4) ? 32'h7FFF0000 : model_cs(ph_a[i]));
    end
    run_stream(8, 1'b1);
    checks++;
    if (out_d.size() != 8) begin
      errors++; $display("FAIL tlast_count: got %0d, want 8", out_d.size());
    end
    for (int i = 0; i < out_d.size(); i++) begin
      checks++;
      if (out_l[i] !== (i == 4) || out_d[i] !== exp_d[i]) begin
        errors++; $display("FAIL tlast_%0d: last=%b data=%h, want last=%b data=%h", i, out_l[i], out_d[i], (i == 4), exp_d[i]);
      end
    end
  endtask

  task automatic test_clear;
    int seen;
    fill_stalled(1'b0);
    @(negedge clk);
    checks++;
    if (bus.o_tvalid !== 1'b1) begin
      errors++; $display("FAIL clear_pre: o_tvalid=%b, want 1", bus.o_tvalid);
    end
    @(posedge clk); #1;
    clear = 1'b1; bus.o_tready = 1'b1; bus.i_tvalid = 1'b1; bus.i_tdata = 16'd2345;
    @(posedge clk); #1;
    clear = 1'b0; bus.i_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_tvalid !== 1'b0 || bus.o_tdata !== 32'd0 || bus.i_tready !== 1'b1) begin
      errors++; $display("FAIL clear_flush: valid=%b data=%h ready=%b, want 0/0/1", bus.o_tvalid, bus.o_tdata, bus.i_tready);
    end
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_tvalid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL clear_drop: %0d stale outputs, want 0", seen);
    end
    ph_a.delete(); last_a.delete(); exp_d.delete();
    ph_a = '{16'd6000, 16'd20000};
    last_a = '{1'b0, 1'b0};
    exp_d = '{model_cs(16'd6000), model_cs(16'd20000)};
    run_stream(2, 1'b0);
    checks++;
    if (out_d.size() != 2 || out_d[0] !== exp_d[0] || out_d[1] !== exp_d[1]) begin
      errors++; $display("FAIL clear_next: got %0d beats first=%h, want 2 first=%h", out_d.size(), (out_d.size() > 0) ? out_d[0] : 32'd0, exp_d[0]);
    end
  endtask

  task automatic test_reset_stall;
    fill_stalled(1'b1);
    @(negedge clk);
    checks++;
    if (bus.o_tvalid !== 1'b1 || bus.o_tlast !== 1'b1) begin
      errors++; $display("FAIL rst_pre: valid=%b last=%b, want 1/1", bus.o_tvalid, bus.o_tlast);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.i_tready !== 1'b1) begin
      errors++; $display("FAIL rst_ready_during: i_tready=%b, want 1", bus.i_tready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_tvalid !== 1'b0 || bus.o_tlast !== 1'b0 || bus.o_tdata !== 32'd0 || bus.i_tready !== 1'b1) begin
      errors++; $display("FAIL rst_stall: valid=%b last=%b data=%h ready=%b, want 0/0/0/1", bus.o_tvalid, bus.o_tlast, bus.o_tdata, bus.i_tready);
    end
    bus.o_tready = 1'b1;
  endtask

  initial begin
    bus.i_tdata = 16'd0; bus.i_tlast = 1'b0; bus.i_tvalid = 1'b0; bus.o_tready = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_tlast();
    test_clear();
    test_reset_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/phase_sincos.md
# phase_sincos

Phase-to-amplitude converter placed directly downstream of the RFNoC phase accumulator. Consumes signed phase words on AXI-Stream, where 2^(WIDTH-2) represents pi, and produces packed cosine/sine samples from a quarter-wave lookup table. The result feeds the mixer or NCO output stage. It is a fixed-latency, stallable three-stage pipeline that passes tlast through unchanged.

## Interface
- WIDTH, 16: input phase width; 2^(WIDTH-2) = pi.
- OUT_WIDTH, 16: width of each of cos and sin, signed.
- LUT_ADDR_WIDTH, 10: quarter-wave address bits A; must satisfy A ≤ WIDTH-3.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- clear  in  1  synchronous pipeline flush; same effect as reset.
- i_tdata  in  WIDTH  signed phase.
- i_tlast  in  1  end of packet, propagated.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  2*OUT_WIDTH  {cos, sin}; cos occupies the upper half.
- o_tlast  out  1  tlast delayed to match the data.
- o_tvalid  out  1  output valid.
- o_tready  in  1  downstream ready.

## Operation
- Phase reduction: p = i_tdata[WIDTH-2:0] as an unsigned value modulo 2^(WIDTH-1). Two's complement makes -x equivalent to 2pi - x; both -2^(WIDTH-2) and +2^(WIDTH-2) map to pi. Bit WIDTH-1 is ignored.
- Quadrant q = p[WIDTH-2:WIDTH-3]. Index k = p[WIDTH-4:WIDTH-3-A]. Lower bits are truncated.
- Table T has 2^A+1 entries. T[j] = round((2^(OUT_WIDTH-1)-1) * sin(pi/2 * j/2^A)). Contents are computed at elaboration. Mirror index m = 2^A - k.
- Sign and index selection by quadrant:
  - q0: sin=+T[k], cos=+T[m]
  - q1: sin=+T[m], cos=-T[k]
  - q2: sin=-T[k], cos=-T[m]
  - q3: sin=-T[m], cos=+T[k]
- Negation is two's complement of a non-negative entry, so -2^(OUT_WIDTH-1) is never produced. -0 = 0.
- Pipeline stages:
  - S1 registers q, k, m and tlast.
  - S2 performs the registered dual-port ROM read.
  - S3 applies signs and drives o_tdata.
- Each stage has its own valid bit.
- tlast is carried alongside the data unmodified. The accumulator's tlast beat (phase 0) therefore emits {max, 0} with o_tlast=1.

## Timing
- Latency is 3 cycles from accepted input to o_tvalid, measured with no stall.
- Global advance = ~o_tvalid | o_tready. i_tready = advance; it is combinational from o_tready and o_tvalid.
- When advance=0, all stages hold: data, valid and tlast are frozen. o_tdata and o_tlast stay stable while o_tvalid=1 and o_tready=0, per AXI rules.
- Bubbles are not collapsed: a stage holds even if downstream stages are empty. This is accepted; throughput is 1 beat/cycle when o_tready=1.
- On reset or clear, which take priority over advance:
  - all valid bits, o_tvalid, o_tlast and o_tdata go to 0 on the next edge;
  - beats in flight are discarded;
  - i_tready is 1 during and after the reset cycle.
- Simultaneous clear and an i_tvalid&i_tready beat: the beat is dropped.

## Configuration
- PHASE_SINCOS_ROUND_EN defined: before decoding, add 2^(WIDTH-4-A) to p modulo 2^(WIDTH-1). The index is then rounded to nearest, and a carry into the quadrant wraps naturally; 2pi-epsilon rounds to 0. This adds no extra latency.
- Undefined: the index is truncated as described above.

## Structure
- Package phase_sincos_pkg holds:
  - quadrant localparams Q0..Q3;
  - a function computing T[j] from OUT_WIDTH and A;
  - a function packing {cos, sin}.
- One sub-module, sincos_quarter_rom: 2^A+1 entries, two read ports, registered outputs with a shared enable tied to advance. It contains stage S2.

## Test plan
All scenarios use WIDTH=16, OUT_WIDTH=16, A=10, with PHASE_SINCOS_ROUND_EN undefined unless stated.
- Phases 0, 8192, 16384, -8192, -16384 with o_tready=1. Expected o_tdata after 3 cycles, in order: {32767,0}, {0,32767}, {-32767,0}, {0,-32767}, {-32767,0}.
- Phase 4096 (pi/4): expect {23170,23170}. Phase 7 differs from 0 only in truncated bits and gives {32767,0}. With PHASE_SINCOS_ROUND_EN, phase 4 gives T[1]: sin=50, cos=32767.
- Backpressure: stream 100 incrementing phases with o_tready toggled randomly. Expect no loss or duplication, in-order output, and o_tdata stable while stalled.
- tlast: beat 5 of 8 carries i_tlast=1 with phase 0. Expect o_tlast=1 only on output beat 5, with data {32767,0}.
- Clear mid-stream with 3 beats in flight: o_tvalid=0 the next cycle, and the next output is the first beat accepted after clear.
- Reset while o_tvalid=1 and o_tready=0: o_tvalid, o_tlast and o_tdata are 0 after the edge, and i_tready=1.
